// File: rtl/detect_sched_if.sv
// detect_sched_if: requester-side bus of the detector scheduler.
//   req           per-lane level request, held until done
//   frame_data    lane r's frame at [r*2*SYMS +: 2*SYMS], symbol i at [2i+1:2i]
//   gnt, done     one-hot grant (CLEAR..REPORT) and one-cycle completion pulse
//   result_*      captured detector flags, valid with done, held until next REPORT
interface detect_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int SYMS = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*2*SYMS-1:0] frame_data;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic result_first;
  logic result_second;
  modport master (output req, frame_data, input gnt, done, result_first, result_second);
  modport slave (input req, frame_data, output gnt, done, result_first, result_second);
endinterface

// File: rtl/detect_sched.sv
// detect_sched: round-robin sharing of one E-then-C letter detector among NUM_REQ requesters.
//   clk, rst_n       clock and asynchronous active-low reset
//   bus              requester bus (req, frame_data, gnt, done, result_first/second)
//   DetMSB, DetLSB   symbol streamed to the detector, det_clr its clear strobe
//   first/second_letter_detected  detector flags, sampled on the last WAIT cycle
//   busy             high whenever not IDLE
//   Macro DETECT_SCHED_STATS_EN adds saturating frame_cnt / hit_cnt outputs.
module detect_sched #(
  parameter int NUM_REQ = 4,
  parameter int SYMS = 4,
  parameter int RESULT_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  detect_sched_if.slave bus,
  output logic DetMSB,
  output logic DetLSB,
  output logic det_clr,
  input  logic first_letter_detected,
  input  logic second_letter_detected,
  output logic busy
`ifdef DETECT_SCHED_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] hit_cnt
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int W = 2 * SYMS;
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, STREAM = 3'd2, WAIT = 3'd3, REPORT = 3'd4;
  logic [2:0] state;
  logic [3:0] cnt;
  logic [IW-1:0] last, idx, sel;
  logic hit;
  logic [W-1:0] frame, sel_frame;
  // Scan downward so the closest set bit after last wins.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req[IW'((int'(last) + k) % NUM_REQ)]) begin
        sel = IW'((int'(last) + k) % NUM_REQ);
        hit = 1'b1;
      end
  end
  always_comb begin
    sel_frame = '0;
    for (int r = 0; r < NUM_REQ; r++)
      if (sel == IW'(r)) sel_frame = bus.frame_data[r*W +: W];
  end
  // Latched frame is consumed as a shift register, symbol 0 first.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= IW'(NUM_REQ - 1);
      idx <= '0;
      frame <= '0;
      bus.gnt <= '0;
      bus.done <= '0;
      bus.result_first <= 1'b0;
      bus.result_second <= 1'b0;
      det_clr <= 1'b0;
      DetMSB <= 1'b0;
      DetLSB <= 1'b0;
      busy <= 1'b0;
`ifdef DETECT_SCHED_STATS_EN
      frame_cnt <= '0;
      hit_cnt <= '0;
`endif
    end else begin
      det_clr <= 1'b0;
      DetMSB <= 1'b0;
      DetLSB <= 1'b0;
      bus.done <= '0;
      case (state)
        IDLE: if (hit) begin
          state <= CLEAR;
          busy <= 1'b1;
          idx <= sel;
          frame <= sel_frame;
          bus.gnt <= NUM_REQ'(1) << sel;
          det_clr <= 1'b1;
        end
        CLEAR: begin
          state <= STREAM;
          cnt <= '0;
          {DetMSB, DetLSB} <= frame[1:0];
          frame <= frame >> 2;
        end
        STREAM: if (cnt == 4'(SYMS - 1)) begin
          state <= WAIT;
          cnt <= '0;
        end else begin
          cnt <= cnt + 4'd1;
          {DetMSB, DetLSB} <= frame[1:0];
          frame <= frame >> 2;
        end
        WAIT: if (cnt == 4'(RESULT_LAT - 1)) begin
          state <= REPORT;
          bus.result_first <= first_letter_detected;
          bus.result_second <= second_letter_detected;
          bus.done <= bus.gnt;
        end else cnt <= cnt + 4'd1;
        REPORT: begin
          state <= IDLE;
          busy <= 1'b0;
          bus.gnt <= '0;
          last <= idx;
`ifdef DETECT_SCHED_STATS_EN
          frame_cnt <= frame_cnt == 16'hFFFF ? frame_cnt : frame_cnt + 16'd1;
          hit_cnt <= bus.result_second && hit_cnt != 16'hFFFF ? hit_cnt + 16'd1 : hit_cnt;
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_detect_sched.sv
// tb_detect_sched: randomized and directed checks of detect_sched against a frame-level reference.
module tb_detect_sched;
  localparam int N = 4, SYMS = 4, RL = 2, W = 2 * SYMS, PERIOD = SYMS + RL + 3;
  localparam logic [1:0] SYM_E = 2'b11, SYM_C = 2'b10;
  logic clk = 1'b0, rst_n = 1'b0;
  logic DetMSB, DetLSB, det_clr, busy;
  logic fld = 1'b0, sld = 1'b0, e_i = 1'b0, c_i = 1'b0;
`ifdef DETECT_SCHED_STATS_EN
  logic [15:0] frame_cnt, hit_cnt;
`endif
  int total = 0, bad = 0, cyc = 0, last_m = N - 1, dc = 0, prev_dc = 0, lane = 0;
  logic [1:0] prev_res = 2'b00;
  logic [W-1:0] f;
  detect_sched_if #(.NUM_REQ(N), .SYMS(SYMS)) bus ();
  detect_sched #(.NUM_REQ(N), .SYMS(SYMS), .RESULT_LAT(RL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .DetMSB(DetMSB),
    .DetLSB(DetLSB),
    .det_clr(det_clr),
    .first_letter_detected(fld),
    .second_letter_detected(sld),
    .busy(busy)
`ifdef DETECT_SCHED_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .hit_cnt(hit_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Stand-in detector: sticky E flag, C flag only after E, two-cycle flag latency.
  always @(posedge clk) begin
    if (det_clr) begin
      e_i <= 1'b0;
      c_i <= 1'b0;
    end else begin
      if (e_i && {DetMSB, DetLSB} == SYM_C) c_i <= 1'b1;
      if ({DetMSB, DetLSB} == SYM_E) e_i <= 1'b1;
    end
    fld <= e_i;
    sld <= c_i;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int next_lane(input logic [N-1:0] r, input int l);
    for (int k = 1; k <= N; k++) if (r[(l + k) % N]) return (l + k) % N;
    return -1;
  endfunction
  function automatic logic [1:0] ref_detect(input logic [W-1:0] fr);
    logic e, c;
    e = 1'b0;
    c = 1'b0;
    for (int i = 0; i < SYMS; i++) begin
      if (e && fr[2*i +: 2] == SYM_C) c = 1'b1;
      if (fr[2*i +: 2] == SYM_E) e = 1'b1;
    end
    return {e, c};
  endfunction
  task automatic wait_gnt();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.gnt != '0) break;
      check("idle_done", 32'(bus.done), 0);
      check("idle_busy", 32'(busy), 0);
    end
    check("gnt_seen", 32'(bus.gnt != '0), 1);
  endtask
  task automatic run_frame(input int ln, input logic [W-1:0] fr, input bit perturb, output int done_cyc);
    logic [1:0] res;
    res = ref_detect(fr);
    wait_gnt();
    check("gnt", 32'(bus.gnt), 32'(1 << ln));
    check("det_clr", 32'(det_clr), 1);
    check("clr_sym", 32'({DetMSB, DetLSB}), 0);
    check("busy", 32'(busy), 1);
    check("res_hold", 32'({bus.result_first, bus.result_second}), 32'(prev_res));
    for (int i = 0; i < SYMS; i++) begin
      @(negedge clk);
      check("sym", 32'({DetMSB, DetLSB}), 32'(fr[2*i +: 2]));
      check("clr_low", 32'(det_clr), 0);
      if (perturb && i == 1) begin
        bus.req[ln] = 1'b0;
        bus.frame_data[ln*W +: W] = ~fr;
      end
    end
    for (int i = 0; i < RL; i++) begin
      @(negedge clk);
      check("wait_sym", 32'({DetMSB, DetLSB}), 0);
      check("early_done", 32'(bus.done), 0);
    end
    @(negedge clk);
    check("done", 32'(bus.done), 32'(1 << ln));
    check("result", 32'({bus.result_first, bus.result_second}), 32'(res));
    check("gnt_report", 32'(bus.gnt), 32'(1 << ln));
    done_cyc = cyc;
    prev_res = res;
    last_m = ln;
  endtask
  task automatic go(input bit perturb);
    lane = next_lane(bus.req, last_m);
    f = bus.frame_data[lane*W +: W];
    run_frame(lane, f, perturb, dc);
  endtask
  task automatic check_zero(input string tag);
    check(tag, 32'({bus.gnt, bus.done, det_clr, DetMSB, DetLSB, bus.result_first, bus.result_second, busy}), 0);
  endtask
  initial begin
    bus.req = '0;
    bus.frame_data = '0;
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_reset");
    bus.frame_data[W-1:0] = 8'h3B;
    bus.req = 4'b0001;
    go(0);
    bus.frame_data[W-1:0] = 8'h00;
    go(0);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < N; r++) bus.frame_data[r*W +: W] = W'($urandom);
      prev_dc = dc;
      go(0);
      if (k > 0) check("spacing", 32'(dc - prev_dc), PERIOD);
    end
    bus.req = 4'b0100;
    bus.frame_data[2*W +: W] = W'($urandom);
    go(1);
    for (int k = 0; k < 12; k++) begin
      bus.req = N'($urandom_range(1, (1 << N) - 1));
      for (int r = 0; r < N; r++) bus.frame_data[r*W +: W] = W'($urandom);
      go(0);
    end
    bus.frame_data[W-1:0] = 8'h3B;
    bus.req = 4'b0001;
    go(0);
    bus.req = 4'b0010;
    wait_gnt();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    last_m = N - 1;
    prev_res = 2'b00;
    bus.req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_done_in_reset", 32'(bus.done), 0);
    end
    rst_n = 1'b1;
    go(0);
    bus.req = 4'b1000;
    go(0);
`ifdef DETECT_SCHED_STATS_EN
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    last_m = N - 1;
    prev_res = 2'b00;
    @(negedge clk);
    check("stats_reset", 32'({frame_cnt, hit_cnt}), 0);
    rst_n = 1'b1;
    bus.req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      bus.frame_data[W-1:0] = k < 3 ? 8'h3B : 8'h00;
      go(0);
    end
    bus.req = '0;
    @(negedge clk);
    check("frame_cnt", 32'(frame_cnt), 5);
    check("hit_cnt", 32'(hit_cnt), 3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/detect_sched.md
# detect_sched

Round-robin scheduler that shares one 2-bit-symbol letter pattern detector (E-then-C detector: MSB/LSB symbol inputs, `first_letter_detected` / `second_letter_detected` outputs) among `NUM_REQ` requesters. Each requester presents a fixed-length frame of symbols. The block performs four steps per frame: grants one requester, clears the detector, streams the frame into it one symbol per cycle, then returns the detector flags to the granted requester with a done pulse. It sits between the requester lanes and the single detector instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `SYMS`, 4: symbols per frame (1..16).
- `RESULT_LAT`, 2: cycles from the last streamed symbol until detector flags are valid (1..4).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester frame request; level, held until done.
- `frame_data`  in  NUM_REQ*2*SYMS  requester r's frame at bits [r*2*SYMS +: 2*SYMS]. Symbol i is bits [2i+1:2i]; bit 2i+1 is MSB.
- `gnt`  out  NUM_REQ  one-hot grant, held from CLEAR through REPORT.
- `DetMSB`, `DetLSB`  out  1 each  symbol driven to the detector.
- `det_clr`  out  1  synchronous clear strobe to the detector.
- `first_letter_detected`, `second_letter_detected`  in  1 each  detector flags.
- `done`  out  NUM_REQ  one-cycle pulse to the granted requester.
- `result_first`, `result_second`  out  1 each  captured flags, valid while `done` is high, held until the next REPORT.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, STREAM, WAIT, REPORT.
- IDLE:
  - If any `req` bit is set, select the first set bit searching upward, modulo NUM_REQ, from `last+1`. `last` is the index of the previous grant; its reset value is NUM_REQ-1, so requester 0 has priority first.
  - Latch that requester's `frame_data`, set `gnt`, go to CLEAR.
- CLEAR (1 cycle): `det_clr`=1, symbol outputs 00. Go to STREAM.
- STREAM (SYMS cycles): drive symbol i on cycle i (i=0..SYMS-1) from the latched frame. Then go to WAIT.
- WAIT (RESULT_LAT cycles): symbol outputs 00. On the last WAIT cycle, sample both detector flags into the result registers. Then go to REPORT.
- REPORT (1 cycle): `done[idx]`=1, `gnt` still set. Update `last`=idx. Go to IDLE, where `gnt` is cleared.
- Requests are only sampled in IDLE.
  - Deasserting `req` mid-frame is ignored: the frame completes and `done` still pulses.
  - A `req` still high in the IDLE after REPORT is treated as a new frame.
- `frame_data` changes after the grant cycle have no effect.
- Outside STREAM, `DetMSB`/`DetLSB` are 0. Outside CLEAR, `det_clr` is 0.
- Reset is asynchronous and may occur in any state. The block returns to IDLE and all outputs go to 0: `gnt`, `done`, `det_clr`, `DetMSB`, `DetLSB`, `result_*` and `busy`. `last` returns to NUM_REQ-1. The in-flight frame is dropped with no `done` pulse.

## Timing
- All outputs are registered.
- `req` is seen in IDLE at edge T. From there:
  - `gnt` and `det_clr` are high during cycle T+1.
  - Symbol i is driven during cycle T+2+i.
  - Flags are sampled at the end of cycle T+1+SYMS+RESULT_LAT.
  - `done` is high during cycle T+2+SYMS+RESULT_LAT.
- Frame period under back-to-back load is SYMS+RESULT_LAT+3 cycles, counting one IDLE cycle. That is 9 cycles at the defaults.
- `busy` equals (state != IDLE), registered with the state.

## Configuration
- `DETECT_SCHED_STATS_EN` defined: adds outputs `frame_cnt[15:0]` and `hit_cnt[15:0]`.
  - `frame_cnt` increments in each REPORT cycle.
  - `hit_cnt` increments in REPORT cycles where `result_second`=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
All scenarios use default parameters and a behavioural detector model with 2-cycle flag latency.
- Single requester: `req`=4'b0001, frame0=8'h3B (symbols 11,10,11,00). Required: `det_clr` on cycle T+1; symbols 11,10,11,00 on T+2..T+5; `done`=4'b0001 at T+8 with `result_first`=1 and `result_second`=1.
- No match: frame0=8'h00. Required: `done` at T+8 with both results 0.
- Fairness: `req`=4'b1111 held continuously. Required: grant order 0,1,2,3,0, with a 9-cycle spacing between `done` pulses.
- Mid-frame change: `req[2]` drops, and `frame_data` for lane 2 changes, two cycles after its grant. Required: the original latched symbols are streamed and `done[2]` still pulses.
- Async reset: assert `rst_n`=0 during STREAM. Required: all outputs go to 0 immediately and no `done` pulse is issued. After release, with `req`=4'b1000, the grant goes to lane 3; after `last` resets, the next grant with `req`=4'b1111 goes to lane 0.
- With `DETECT_SCHED_STATS_EN` defined: run 3 frames of 8'h3B and 2 frames of 8'h00. Required: `frame_cnt`=5 and `hit_cnt`=3.
